// File: rtl/piradip_axis_packetizer_if.sv
// AXI4-Stream bundle shared by the packetizer's input and output sides.
interface piradip_axis_packetizer_if #(
    parameter int WIDTH = 32
);
    logic               tvalid;
    logic               tready;
    logic [WIDTH-1:0]   tdata;
    logic               tlast;
    logic [WIDTH/8-1:0] tkeep;

    modport master (output tvalid, tdata, tlast, tkeep, input tready);
    modport slave  (input tvalid, tdata, tlast, tkeep, output tready);
endinterface

// File: rtl/piradip_axis_packetizer.sv
// Groups an unframed AXI4-Stream into fixed-length packets behind a 2-entry skid buffer.
// Optional PIRADIP_AXIS_PKTZ_EARLY_LAST_EN: input tlast also closes the current packet.
module piradip_axis_packetizer #(
    parameter int WIDTH     = 32,
    parameter int LEN_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [LEN_WIDTH-1:0]  pkt_len,
    piradip_axis_packetizer_if.slave  s_axis,
    piradip_axis_packetizer_if.master m_axis,
    output logic                  busy,
    output logic [31:0]           pkt_count
);
    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t               state_q, state_d;
    logic [LEN_WIDTH-1:0] len_q, len_d;
    logic [LEN_WIDTH-1:0] beat_cnt_q, beat_cnt_d;
    logic                 rdy_q, rdy_d;
    logic                 out_vld_q, out_vld_d;
    logic [WIDTH-1:0]     out_data_q, out_data_d;
    logic                 out_last_q, out_last_d;
    logic                 skid_vld_q, skid_vld_d;
    logic [WIDTH-1:0]     skid_data_q, skid_data_d;
    logic                 skid_last_q, skid_last_d;
    logic [31:0]          pkt_cnt_q, pkt_cnt_d;

    logic                 in_hs, out_hs, beat_last, early_last;
    logic [LEN_WIDTH-1:0] eff_len;
    logic                 unused_ok;

`ifdef PIRADIP_AXIS_PKTZ_EARLY_LAST_EN
    assign early_last = s_axis.tlast;
    assign unused_ok  = &{1'b0, s_axis.tkeep};
`else
    assign early_last = 1'b0;
    assign unused_ok  = &{1'b0, s_axis.tkeep, s_axis.tlast};
`endif

    // rdy_q only tracks skid occupancy, so m_axis.tready never reaches s_axis.tready
    assign s_axis.tready = rdy_q && ((state_q == ACTIVE) || enable);
    assign in_hs         = s_axis.tvalid && s_axis.tready;
    assign out_hs        = out_vld_q && m_axis.tready;
    assign eff_len       = (pkt_len == '0) ? LEN_WIDTH'(1) : pkt_len;

    assign m_axis.tvalid = out_vld_q;
    assign m_axis.tdata  = out_data_q;
    assign m_axis.tlast  = out_last_q;
    assign m_axis.tkeep  = '1;
    assign busy          = (state_q == ACTIVE) || out_vld_q || skid_vld_q;
    assign pkt_count     = pkt_cnt_q;

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        beat_cnt_d = beat_cnt_q;
        beat_last  = 1'b0;
        if (in_hs) begin
            if (state_q == IDLE) begin
                len_d     = eff_len;
                beat_last = (eff_len == LEN_WIDTH'(1)) || early_last;
            end else begin
                beat_last = (beat_cnt_q == len_q - LEN_WIDTH'(1)) || early_last;
            end
            if (beat_last) begin
                beat_cnt_d = '0;
                state_d    = IDLE;
            end else begin
                beat_cnt_d = beat_cnt_q + LEN_WIDTH'(1);
                state_d    = ACTIVE;
            end
        end
    end

    always_comb begin
        out_vld_d   = out_vld_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        skid_vld_d  = skid_vld_q;
        skid_data_d = skid_data_q;
        skid_last_d = skid_last_q;
        if (out_hs || !out_vld_q) begin
            // Output slot frees up: skid entry is older, so it moves first
            if (skid_vld_q) begin
                out_vld_d  = 1'b1;
                out_data_d = skid_data_q;
                out_last_d = skid_last_q;
                skid_vld_d = in_hs;
                if (in_hs) begin
                    skid_data_d = s_axis.tdata;
                    skid_last_d = beat_last;
                end
            end else begin
                out_vld_d = in_hs;
                if (in_hs) begin
                    out_data_d = s_axis.tdata;
                    out_last_d = beat_last;
                end
            end
        end else if (in_hs) begin
            skid_vld_d  = 1'b1;
            skid_data_d = s_axis.tdata;
            skid_last_d = beat_last;
        end
        rdy_d     = !skid_vld_d;
        pkt_cnt_d = pkt_cnt_q;
        if (out_hs && out_last_q)
            pkt_cnt_d = pkt_cnt_q + 32'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            len_q       <= '0;
            beat_cnt_q  <= '0;
            rdy_q       <= 1'b0;
            out_vld_q   <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            skid_vld_q  <= 1'b0;
            skid_data_q <= '0;
            skid_last_q <= 1'b0;
            pkt_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            beat_cnt_q  <= beat_cnt_d;
            rdy_q       <= rdy_d;
            out_vld_q   <= out_vld_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            skid_vld_q  <= skid_vld_d;
            skid_data_q <= skid_data_d;
            skid_last_q <= skid_last_d;
            pkt_cnt_q   <= pkt_cnt_d;
        end
    end
endmodule

// File: tb/tb_piradip_axis_packetizer.sv
// Randomized + directed bench for piradip_axis_packetizer against a packet-position reference model.
module tb_piradip_axis_packetizer;
    localparam int WIDTH = 32;
    localparam int LW    = 16;
`ifdef PIRADIP_AXIS_PKTZ_EARLY_LAST_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic [LW-1:0] pkt_len;
    logic          busy;
    logic [31:0]   pkt_count;

    piradip_axis_packetizer_if #(.WIDTH(WIDTH)) s_if ();
    piradip_axis_packetizer_if #(.WIDTH(WIDTH)) m_if ();

    piradip_axis_packetizer #(.WIDTH(WIDTH), .LEN_WIDTH(LW)) dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .pkt_len  (pkt_len),
        .s_axis   (s_if),
        .m_axis   (m_if),
        .busy     (busy),
        .pkt_count(pkt_count)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0, n_fail = 0;

    task automatic chk(string tag, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    // reference model: beats in flight and position within the open packet
    logic [WIDTH-1:0] q_data[$];
    bit               q_last[$];
    bit               m_in_pkt = 0;
    int               m_len = 1, m_pos = 0, exp_pkts = 0;

    // source / sink control
    int  feed = 0, vprob = 100, rprob = 100, nxt = 0, tlast_at = -1;
    bit  rand_data = 0, rand_tlast = 0, acc = 0;
    int  in_cnt = 0, out_cnt = 0, cyc = 0, first_out = -1, last_out = -1;
    bit  stall_prev = 0;
    logic [WIDTH-1:0] stall_data;
    logic             stall_last;

    task automatic model_reset();
        q_data.delete();
        q_last.delete();
        m_in_pkt   = 0;
        exp_pkts   = 0;
        stall_prev = 0;
    endtask

    task automatic monitor();
        bit ih, oh, lst;
        logic [WIDTH-1:0] d;
        cyc++;
        ih = s_if.tvalid && s_if.tready;
        oh = m_if.tvalid && m_if.tready;
        acc = 0;
        if (reset) return;
        if (stall_prev) begin
            chk("hold_vld", m_if.tvalid, 1);
            chk("hold_data", m_if.tdata, stall_data);
            chk("hold_last", m_if.tlast, stall_last);
        end
        stall_prev = m_if.tvalid && !m_if.tready;
        stall_data = m_if.tdata;
        stall_last = m_if.tlast;
        chk("pkt_count", pkt_count, exp_pkts);
        chk("busy", busy, m_in_pkt || q_data.size() > 0);
        if (!m_in_pkt && !enable) chk("idle_gate", s_if.tready, 0);
        if (oh) begin
            if (q_data.size() == 0) chk("spurious_out", 1, 0);
            else begin
                d   = q_data.pop_front();
                lst = q_last.pop_front();
                chk("out_data", m_if.tdata, d);
                chk("out_last", m_if.tlast, lst);
                if (lst) exp_pkts++;
                out_cnt++;
                if (first_out < 0) first_out = cyc;
                last_out = cyc;
            end
        end
        if (ih) begin
            if (!m_in_pkt) begin
                m_len    = (pkt_len == 0) ? 1 : int'(pkt_len);
                m_pos    = 0;
                m_in_pkt = 1;
            end
            lst = (m_pos == m_len - 1) || (EARLY && s_if.tlast);
            m_pos++;
            if (lst) m_in_pkt = 0;
            q_data.push_back(s_if.tdata);
            q_last.push_back(lst);
            in_cnt++;
        end
        chk("inflight_le2", q_data.size() <= 2, 1);
        acc = ih;
    endtask

    task automatic cycle();
        bit held;
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        if (acc) begin
            nxt++;
            feed--;
        end
        held = s_if.tvalid && !acc;
        if (feed > 0 && (held || $urandom_range(99) < vprob)) begin
            if (!held) begin
                s_if.tdata = rand_data ? $urandom : WIDTH'(nxt);
                s_if.tlast = rand_tlast ? ($urandom_range(7) == 0) : (nxt == tlast_at);
            end
            s_if.tvalid = 1'b1;
        end else begin
            s_if.tvalid = 1'b0;
        end
        m_if.tready = ($urandom_range(99) < rprob);
    endtask

    task automatic start_feed(int n);
        feed        = n;
        nxt         = 0;
        in_cnt      = 0;
        out_cnt     = 0;
        s_if.tvalid = 1'b1;
        s_if.tdata  = '0;
        s_if.tlast  = (tlast_at == 0);
        m_if.tready = 1'b1;
    endtask

    task automatic run_until_done(int budget);
        int b = budget;
        while ((feed > 0 || q_data.size() > 0) && b > 0) begin
            cycle();
            b--;
        end
        chk("drained", (feed == 0 && q_data.size() == 0), 1);
    endtask

    initial begin
        int b, base;
        reset       = 1'b1;
        enable      = 1'b0;
        pkt_len     = 16'd4;
        s_if.tvalid = 1'b0;
        s_if.tdata  = '0;
        s_if.tlast  = 1'b0;
        s_if.tkeep  = '1;
        m_if.tready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_s_tready", s_if.tready, 0);
        chk("rst_m_tvalid", m_if.tvalid, 0);
        chk("rst_m_tdata", m_if.tdata, 0);
        chk("rst_m_tlast", m_if.tlast, 0);
        chk("rst_busy", busy, 0);
        chk("rst_pkt_count", pkt_count, 0);
        chk("tkeep", m_if.tkeep, 4'hF);
        reset = 1'b0;

        // 1: two 4-beat packets at full rate
        enable = 1'b1;
        first_out = -1;
        start_feed(8);
        run_until_done(60);
        chk("t1_consecutive", last_out - first_out, 7);
        chk("t1_pkts", pkt_count, 2);

        // 2: downstream stall for 3 cycles after output beat 1
        start_feed(8);
        b = 50;
        while (out_cnt < 2 && b > 0) begin cycle(); b--; end
        chk("t2_reach_beat1", out_cnt, 2);
        for (int i = 0; i < 3; i++) begin
            m_if.tready = 1'b0;
            chk("t2_bp_tready", s_if.tready, (i == 0));
            cycle();
        end
        run_until_done(60);
        chk("t2_pkts", pkt_count, 4);

        // 3: enable dropped mid-packet lets the packet finish, then gates
        pkt_len = 16'd5;
        start_feed(20);
        b = 50;
        while (in_cnt < 3 && b > 0) begin cycle(); b--; end
        enable = 1'b0;
        repeat (8) cycle();
        chk("t3_accepted", in_cnt, 5);
        chk("t3_tready_low", s_if.tready, 0);
        chk("t3_pkts", pkt_count, 5);
        enable = 1'b1;
        feed   = 5;
        run_until_done(60);

        // 4: zero length means single-beat packets; length change mid-packet deferred
        base    = int'(pkt_count);
        pkt_len = 16'd0;
        start_feed(3);
        run_until_done(40);
        chk("t4_len0_pkts", pkt_count - base, 3);
        pkt_len = 16'd4;
        start_feed(8);
        b = 50;
        while (in_cnt < 1 && b > 0) begin cycle(); b--; end
        pkt_len = 16'd2;
        run_until_done(60);
        chk("t4_len_change_pkts", pkt_count - base, 6);

        // 5: reset in the middle of a 4-beat packet
        pkt_len = 16'd4;
        start_feed(10);
        b = 50;
        while (in_cnt < 2 && b > 0) begin cycle(); b--; end
        reset = 1'b1;
        #2;
        chk("t5_s_tready", s_if.tready, 0);
        chk("t5_m_tvalid", m_if.tvalid, 0);
        chk("t5_m_tdata", m_if.tdata, 0);
        chk("t5_m_tlast", m_if.tlast, 0);
        chk("t5_busy", busy, 0);
        chk("t5_pkt_count", pkt_count, 0);
        model_reset();
        cycle();
        cycle();
        reset = 1'b0;
        feed  = 4;
        run_until_done(60);
        chk("t5_pkts", pkt_count, 1);

        // 6: input tlast on beat 2 of an 8-beat packet
        base     = int'(pkt_count);
        pkt_len  = 16'd8;
        tlast_at = 2;
        start_feed(EARLY ? 11 : 16);
        run_until_done(80);
        chk("t6_pkts", pkt_count - base, 2);
        tlast_at = -1;

        // 7: random lengths, enable, valid/ready density and data
        rand_data  = 1;
        rand_tlast = 1;
        feed       = 100000;
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) begin
                vprob = $urandom_range(20, 100);
                rprob = $urandom_range(10, 100);
            end
            if ($urandom_range(15) == 0) pkt_len = LW'($urandom_range(0, 6));
            if ($urandom_range(19) == 0) enable = ~enable;
            cycle();
        end
        enable = 1'b1;
        rprob  = 100;
        feed   = 0;
        run_until_done(100);
        chk("t7_pkt_count", pkt_count, exp_pkts);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
